// File: rtl/kbd_event.sv
// PS/2 scan-byte decoder: strips E0/F0 prefixes, flags typematic repeats and
// queues {ext, release, repeat, code} events in a small FIFO for the consumer.
module kbd_event #(
    parameter int DEPTH           = 4,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       code_valid,
    input  logic [7:0]                 code_data,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [7:0]                 ev_code,
    output logic                       ev_ext,
    output logic                       ev_release,
    output logic                       ev_repeat,
    output logic [$clog2(DEPTH):0]     ev_count,
    output logic                       overflow,
    output logic                       proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK
    } state_t;

    state_t state_q, state_d;

    logic         proto_err_q, proto_err_d;
    logic         overflow_q, overflow_d;
    logic         lm_valid_q, lm_valid_d;
    logic         lm_ext_q, lm_ext_d;
    logic [7:0]   lm_code_q, lm_code_d;

    logic [10:0]  mem_q [DEPTH];
    logic [10:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic         ev_form;
    logic         form_ext;
    logic         form_rel;
    logic         lm_match;
    logic         is_repeat;
    logic         push_req;
    logic [10:0]  push_entry;
    logic         do_pop;
    logic         can_push;
    logic         do_push;
    logic [10:0]  head;

    // Prefix decoder: only advances on cycles carrying a scan byte.
    always_comb begin
        state_d     = state_q;
        proto_err_d = proto_err_q;
        ev_form     = 1'b0;
        form_ext    = 1'b0;
        form_rel    = 1'b0;
        if (code_valid) begin
            if (code_data == 8'h00 || code_data == 8'hFF) begin
                proto_err_d = 1'b1;
                state_d     = ST_IDLE;
            end else if (code_data == 8'hE0) begin
                case (state_q)
                    ST_IDLE: state_d = ST_EXT;
                    ST_BRK:  state_d = ST_IDLE;
                    default: state_d = state_q;
                endcase
            end else if (code_data == 8'hF0) begin
                case (state_q)
                    ST_IDLE: state_d = ST_BRK;
                    ST_EXT:  state_d = ST_EXTBRK;
                    default: state_d = state_q;
                endcase
            end else begin
                ev_form  = 1'b1;
                form_ext = (state_q == ST_EXT) || (state_q == ST_EXTBRK);
                form_rel = (state_q == ST_BRK) || (state_q == ST_EXTBRK);
                state_d  = ST_IDLE;
            end
        end
    end

    // Last-make tracking decides whether a make is a typematic repeat.
    always_comb begin
        lm_valid_d = lm_valid_q;
        lm_ext_d   = lm_ext_q;
        lm_code_d  = lm_code_q;
        lm_match   = lm_valid_q && (lm_ext_q == form_ext) && (lm_code_q == code_data);
        is_repeat  = 1'b0;
        push_req   = 1'b0;
        if (ev_form) begin
            if (!form_rel) begin
                if (lm_match) begin
                    is_repeat = 1'b1;
                end else begin
                    lm_valid_d = 1'b1;
                    lm_ext_d   = form_ext;
                    lm_code_d  = code_data;
                end
                push_req = !(is_repeat && SUPPRESS_REPEAT);
            end else begin
                if (lm_match) begin
                    lm_valid_d = 1'b0;
                end
                push_req = 1'b1;
            end
        end
        push_entry = {form_ext, form_rel, is_repeat, code_data};
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop     = ev_valid && ev_ready;
        can_push   = (count_q != CW'(DEPTH)) || do_pop;
        do_push    = push_req && can_push;
        overflow_d = overflow_q | (push_req & ~can_push);
        mem_d      = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
        end
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            proto_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            lm_valid_q  <= 1'b0;
            lm_ext_q    <= 1'b0;
            lm_code_q   <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
            overflow_q  <= overflow_d;
            lm_valid_q  <= lm_valid_d;
            lm_ext_q    <= lm_ext_d;
            lm_code_q   <= lm_code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        ev_valid   = (count_q != '0);
        ev_code    = ev_valid ? head[7:0] : 8'h00;
        ev_repeat  = ev_valid & head[8];
        ev_release = ev_valid & head[9];
        ev_ext     = ev_valid & head[10];
        ev_count   = count_q;
        overflow   = overflow_q;
        proto_err  = proto_err_q;
    end

endmodule

// File: tb/tb_kbd_event.sv
// Bench for kbd_event: two instances (repeats suppressed / emitted) checked every
// cycle against a queue-based model driven by directed and random scan bytes.
module tb_kbd_event;

    logic       clk = 1'b0;
    logic       rst;
    logic       code_valid;
    logic [7:0] code_data;
    logic       ev_ready;

    logic       ev_valid_w   [2];
    logic [7:0] ev_code_w    [2];
    logic       ev_ext_w     [2];
    logic       ev_release_w [2];
    logic       ev_repeat_w  [2];
    logic [2:0] ev_count_w   [2];
    logic       overflow_w   [2];
    logic       proto_err_w  [2];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: prefix flags, last-make and plain queues per instance.
    bit         pend_ext [2];
    bit         pend_brk [2];
    bit         lm_v     [2];
    bit         lm_e     [2];
    logic [7:0] lm_c     [2];
    bit         ovf      [2];
    bit         perr     [2];
    bit         suppress [2];
    logic [10:0] q0 [$];
    logic [10:0] q1 [$];

    always #5 clk = ~clk;

    kbd_event #(.DEPTH(4), .SUPPRESS_REPEAT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code_data(code_data),
        .ev_valid(ev_valid_w[0]), .ev_ready(ev_ready), .ev_code(ev_code_w[0]),
        .ev_ext(ev_ext_w[0]), .ev_release(ev_release_w[0]), .ev_repeat(ev_repeat_w[0]),
        .ev_count(ev_count_w[0]), .overflow(overflow_w[0]), .proto_err(proto_err_w[0])
    );

    kbd_event #(.DEPTH(4), .SUPPRESS_REPEAT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code_data(code_data),
        .ev_valid(ev_valid_w[1]), .ev_ready(ev_ready), .ev_code(ev_code_w[1]),
        .ev_ext(ev_ext_w[1]), .ev_release(ev_release_w[1]), .ev_repeat(ev_repeat_w[1]),
        .ev_count(ev_count_w[1]), .overflow(overflow_w[1]), .proto_err(proto_err_w[1])
    );

    function automatic int q_size(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [10:0] q_head(int i);
        if (q_size(i) == 0) return 11'h000;
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(int i);
        pend_ext[i] = 0; pend_brk[i] = 0;
        lm_v[i] = 0; lm_e[i] = 0; lm_c[i] = 8'h00;
        ovf[i] = 0; perr[i] = 0;
        if (i == 0) q0.delete(); else q1.delete();
    endtask

    // One clock edge of behaviour, using the values the inputs held at the edge.
    task automatic model_step(int i);
        bit          pop;
        bit          push;
        bit          e;
        bit          r;
        bit          rep;
        logic [10:0] entry;
        if (rst) begin
            model_reset(i);
            return;
        end
        pop   = ev_ready && (q_size(i) > 0);
        push  = 0;
        entry = '0;
        if (code_valid) begin
            if (code_data == 8'h00 || code_data == 8'hFF) begin
                perr[i] = 1; pend_ext[i] = 0; pend_brk[i] = 0;
            end else if (code_data == 8'hE0) begin
                if (pend_brk[i] && !pend_ext[i]) begin
                    pend_brk[i] = 0;
                end else begin
                    pend_ext[i] = 1;
                end
            end else if (code_data == 8'hF0) begin
                pend_brk[i] = 1;
            end else begin
                e = pend_ext[i];
                r = pend_brk[i];
                pend_ext[i] = 0; pend_brk[i] = 0;
                if (!r) begin
                    rep = lm_v[i] && lm_e[i] == e && lm_c[i] == code_data;
                    if (!rep) begin
                        lm_v[i] = 1; lm_e[i] = e; lm_c[i] = code_data;
                    end
                    push  = !(rep && suppress[i]);
                    entry = {e, 1'b0, rep, code_data};
                end else begin
                    if (lm_v[i] && lm_e[i] == e && lm_c[i] == code_data) lm_v[i] = 0;
                    push  = 1;
                    entry = {e, 1'b1, 1'b0, code_data};
                end
            end
        end
        if (pop) begin
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (push) begin
            if (q_size(i) < 4) begin
                if (i == 0) q0.push_back(entry); else q1.push_back(entry);
            end else begin
                ovf[i] = 1;
            end
        end
    endtask

    task automatic checkOutput();
        logic [10:0] h;
        int          sz;
        for (int i = 0; i < 2; i++) begin
            sz = q_size(i);
            h  = q_head(i);
            cmp($sformatf("ev_valid[%0d]", i),   32'(ev_valid_w[i]),   32'(sz > 0));
            cmp($sformatf("ev_count[%0d]", i),   32'(ev_count_w[i]),   32'(sz));
            cmp($sformatf("ev_code[%0d]", i),    32'(ev_code_w[i]),    32'(h[7:0]));
            cmp($sformatf("ev_ext[%0d]", i),     32'(ev_ext_w[i]),     32'(h[10]));
            cmp($sformatf("ev_release[%0d]", i), 32'(ev_release_w[i]), 32'(h[9]));
            cmp($sformatf("ev_repeat[%0d]", i),  32'(ev_repeat_w[i]),  32'(h[8]));
            cmp($sformatf("overflow[%0d]", i),   32'(overflow_w[i]),   32'(ovf[i]));
            cmp($sformatf("proto_err[%0d]", i),  32'(proto_err_w[i]),  32'(perr[i]));
        end
    endtask

    task automatic applyStimulus(bit cv, logic [7:0] cd, bit rdy, bit rs);
        @(negedge clk);
        code_valid = cv;
        code_data  = cd;
        ev_ready   = rdy;
        rst        = rs;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        checkOutput();
    endtask

    task automatic send(logic [7:0] b, bit rdy);
        applyStimulus(1'b1, b, rdy, 1'b0);
    endtask

    task automatic idle(int n, bit rdy);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00, rdy, 1'b0);
    endtask

    initial begin
        int          r;
        logic [7:0]  b;
        logic [7:0]  common [3];
        common[0] = 8'h1C; common[1] = 8'h75; common[2] = 8'h15;
        suppress[0] = 1; suppress[1] = 0;
        code_valid = 0; code_data = 8'h00; ev_ready = 0; rst = 1;
        model_reset(0); model_reset(1);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        cmp("reset_count", 32'(ev_count_w[0]), 32'd0);

        // Make then break of 1C with the consumer always ready.
        send(8'h1C, 1); idle(1, 1);
        send(8'hF0, 1); send(8'h1C, 1);
        cmp("brk_valid", 32'(ev_valid_w[0]), 32'd1);
        cmp("brk_release", 32'(ev_release_w[0]), 32'd1);
        idle(2, 1);

        // Extended make and break.
        send(8'hE0, 1); send(8'h75, 1);
        cmp("ext_make", 32'({ev_ext_w[0], ev_release_w[0], ev_code_w[0]}), 32'h275);
        send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
        cmp("ext_break", 32'({ev_ext_w[0], ev_release_w[0], ev_code_w[0]}), 32'h375);
        idle(2, 1);

        // Typematic repeats: held key then released, consumer stalled.
        send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
        cmp("rep_count_supp", 32'(ev_count_w[0]), 32'd2);
        cmp("rep_count_emit", 32'(ev_count_w[1]), 32'd4);
        idle(5, 1);

        // Overflow with five makes, then full FIFO push+pop in one cycle.
        send(8'h15, 0); send(8'h1D, 0); send(8'h24, 0); send(8'h2D, 0); send(8'h2C, 0);
        cmp("ovf_count", 32'(ev_count_w[0]), 32'd4);
        cmp("ovf_flag", 32'(overflow_w[0]), 32'd1);
        cmp("ovf_head", 32'(ev_code_w[0]), 32'h15);
        send(8'h1C, 1);
        cmp("full_swap_count", 32'(ev_count_w[0]), 32'd4);
        cmp("full_swap_head", 32'(ev_code_w[0]), 32'h1D);
        idle(6, 1);

        // Partial sequence abandoned by reset.
        send(8'hE0, 0); send(8'hF0, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        cmp("rst_count", 32'(ev_count_w[0]), 32'd0);
        cmp("rst_flags", 32'({overflow_w[0], proto_err_w[0]}), 32'd0);
        send(8'h1C, 0);
        cmp("post_rst_ev", 32'({ev_ext_w[0], ev_release_w[0], ev_code_w[0]}), 32'h01C);
        idle(2, 1);

        // Protocol error in the middle of a break sequence.
        send(8'hF0, 0); send(8'hFF, 0); send(8'h1C, 0);
        cmp("perr_flag", 32'(proto_err_w[0]), 32'd1);
        idle(3, 1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      b = 8'hE0;
            else if (r < 35) b = 8'hF0;
            else if (r < 37) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            else if (r < 80) b = common[$urandom_range(0, 2)];
            else             b = 8'($urandom_range(1, 254));
            applyStimulus(($urandom_range(0, 2) != 0), b, ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/kbd_event.md
KBD_EVENT -- requirements
Module: kbd_event

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning event FIFO depth (power of 2, 2..16).
REQ-002 The module SHALL have parameter SUPPRESS_REPEAT, default 1, meaning 1 = drop typematic repeats and 0 = emit them with ev_repeat=1.
REQ-003 Port clk, input, 1 bit: single system clock, all logic on posedge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port code_valid, input, 1 bit: one-cycle strobe, one per received PS/2 scan byte.
REQ-006 Port code_data, input, 8 bits: scan byte, qualified by code_valid.
REQ-007 Port ev_valid, output, 1 bit: FIFO non-empty, head event presented.
REQ-008 Port ev_ready, input, 1 bit: consumer accepts head when high with ev_valid.
REQ-009 Port ev_code, output, 8 bits: head event scan code (prefixes stripped).
REQ-010 Port ev_ext, output, 1 bit: head event was E0-prefixed.
REQ-011 Port ev_release, output, 1 bit: head event is a break (key up).
REQ-012 Port ev_repeat, output, 1 bit: head event is a typematic repeat; always 0 when SUPPRESS_REPEAT=1.
REQ-013 Port ev_count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-014 Port overflow, output, 1 bit: sticky; an event was dropped because the FIFO was full.
REQ-015 Port proto_err, output, 1 bit: sticky; a 0x00 or 0xFF byte was received.

Function
REQ-016 Decoder states SHALL be IDLE, EXT (E0 seen), BRK (F0 seen) and EXTBRK (E0 then F0 seen), evaluated only on cycles with code_valid=1.
REQ-017 The decoder SHALL take these transitions on E0: IDLE->EXT; BRK->IDLE, byte discarded; EXT and EXTBRK unchanged.
REQ-018 The decoder SHALL take these transitions on F0: IDLE->BRK; EXT->EXTBRK; BRK and EXTBRK unchanged.
REQ-019 On 0x00 or 0xFF in any state the decoder SHALL set proto_err, discard the byte, go to IDLE and form no event.
REQ-020 Any other byte SHALL form an event {ext, release, code} with ext=1 in EXT/EXTBRK, release=1 in BRK/EXTBRK and code=byte, then the decoder SHALL return to IDLE.
REQ-021 The block SHALL keep a last-make register {lm_valid, lm_ext, lm_code}.
REQ-022 A make event equal to a valid last-make SHALL be a repeat.
REQ-023 A make event that is not a repeat SHALL load last-make.
REQ-024 A break event whose {ext, code} equals last-make SHALL clear lm_valid.
REQ-025 A break event that does not match last-make SHALL leave it unchanged.
REQ-026 A repeat SHALL be discarded when SUPPRESS_REPEAT=1, and pushed with ev_repeat=1 otherwise.
REQ-027 Event formation and FIFO push SHALL occur in the clock edge that samples the final byte's code_valid; ev_valid/ev_count SHALL reflect it in the next cycle (1-cycle latency).
REQ-028 The FIFO SHALL be DEPTH entries of 11 bits {ext, release, repeat, code}, first-in first-out, with read and write pointers that wrap modulo DEPTH.
REQ-029 Pop SHALL occur when ev_valid && ev_ready, advancing the head on that edge.
REQ-030 Push SHALL be accepted when ev_count < DEPTH, or when ev_count == DEPTH and a pop occurs in the same cycle.
REQ-031 An event that cannot be pushed SHALL be dropped and set overflow; the FIFO contents SHALL be unchanged.
REQ-032 Simultaneous push and pop SHALL leave ev_count unchanged.
REQ-033 Pop on empty SHALL have no effect.
REQ-034 ev_code, ev_ext, ev_release and ev_repeat SHALL be 0 whenever ev_valid=0.
REQ-035 The head event SHALL remain stable while ev_valid=1 and ev_ready=0.
REQ-036 overflow and proto_err SHALL clear only on rst.

Reset
REQ-037 On rst=1 at a clock edge: state=IDLE, lm_valid=0, FIFO empty (pointers 0), ev_valid=0, ev_count=0, ev_code=ev_ext=ev_release=ev_repeat=0, overflow=0, proto_err=0.
REQ-038 rst SHALL override a simultaneous code_valid or pop; a partially received sequence (for example after E0 F0) SHALL be abandoned with no event.
REQ-039 The first byte after reset SHALL be decoded from IDLE.

Verification
REQ-040 Bytes 1C, F0, 1C with ev_ready=1 -> events {1C,ext0,rel0,rep0} then {1C,ext0,rel1,rep0}; ev_valid high 1 cycle after each final byte.
REQ-041 Bytes E0 75, E0 F0 75 -> events {75,ext1,rel0} then {75,ext1,rel1}; state back to IDLE.
REQ-042 SUPPRESS_REPEAT=1, bytes 1C 1C 1C F0 1C -> exactly 2 events (make, break); with SUPPRESS_REPEAT=0 -> 4 events, the middle two with ev_repeat=1.
REQ-043 DEPTH=4, ev_ready=0, 5 make codes 15 1D 24 2D 2C -> ev_count=4, overflow=1, pop order 15 1D 24 2D; with the FIFO full, push and pop in the same cycle -> both accepted, ev_count stays 4, overflow unchanged.
REQ-044 Bytes E0 F0, then rst pulse, then 1C -> a single event {1C,ext0,rel0}; ev_count=0 and flags=0 immediately after rst.
REQ-045 Byte FF mid-sequence (F0 FF 1C) -> proto_err=1, one event {1C,rel0}.
